// File: rtl/tpram_wbuf_wrapper.sv
// Pseudo-two-port RAM on a single-port array: reads have priority; writes are
// queued in a small byte-masked buffer that drains into the array in idle-read cycles.
module tpram_wbuf_wrapper #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 32,
    parameter int WB_DEPTH   = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_req,
    output logic            rd_ready,
    input  logic [AW-1:0]   rd_addr,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    input  logic            wr_req,
    output logic            wr_ready,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [DW/8-1:0] wr_be,
    output logic            wbuf_empty
);

    localparam int BW = DW / 8;
    localparam int PW = $clog2(WB_DEPTH);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wb_addr [WB_DEPTH];
    logic [DW-1:0] wb_data [WB_DEPTH];
    logic [BW-1:0] wb_be   [WB_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [SW-1:0] starve_cnt;

    logic          full;
    logic          force_drain;
    logic          rd_fire;
    logic          wr_fire;
    logic          drain;
    logic          mem_we;

    logic [DW-1:0] fwd_data;
    logic [BW-1:0] fwd_mask;
    logic [PW-1:0] slot;

    logic [DW-1:0] mem_q;
    logic [DW-1:0] fwd_data_q;
    logic [BW-1:0] fwd_mask_q;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    assign full        = (count == (PW+1)'(WB_DEPTH));
    assign wr_ready    = !full;
    assign wbuf_empty  = (count == '0);
    assign force_drain = (starve_cnt == SW'(STARVE_LIM - 1));
    assign rd_ready    = !force_drain;
    assign rd_fire     = rd_req && rd_ready;
    assign wr_fire     = wr_req && wr_ready;
    assign drain       = !rd_fire && (count != '0);
    // The array has no reset, so a drain must not land while reset is asserted.
    assign mem_we      = drain && !rst && in_range(wb_addr[head]);

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (wr_fire) tail <= tail + 1'b1;
            if (drain)   head <= head + 1'b1;
            case ({wr_fire, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drain || !full)
                starve_cnt <= '0;
            else if (rd_req)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            wb_addr[tail] <= wr_addr;
            wb_data[tail] <= wr_data;
            wb_be[tail]   <= wr_be;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BW; b++) begin
                if (wb_be[head][b])
                    mem[wb_addr[head][IW-1:0]][8*b +: 8] <= wb_data[head][8*b +: 8];
            end
        end
    end

    // Walk buffered entries oldest to youngest so the youngest byte wins.
    always_comb begin
        fwd_data = '0;
        fwd_mask = '0;
        slot     = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = head + PW'(i);
            if (((PW+1)'(i) < count) && (wb_addr[slot] == rd_addr)) begin
                for (int b = 0; b < BW; b++) begin
                    if (wb_be[slot][b]) begin
                        fwd_data[8*b +: 8] = wb_data[slot][8*b +: 8];
                        fwd_mask[b]        = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            mem_q      <= '0;
            fwd_data_q <= '0;
            fwd_mask_q <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                mem_q      <= in_range(rd_addr) ? mem[rd_addr[IW-1:0]] : '0;
                fwd_data_q <= fwd_data;
                fwd_mask_q <= fwd_mask;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int b = 0; b < BW; b++)
            rd_data[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : mem_q[8*b +: 8];
    end

endmodule

// File: tb/tb_tpram_wbuf_wrapper.sv
// Scenario bench for tpram_wbuf_wrapper: expected read data is queued at issue
// and matched against the data collected from rd_valid pulses.
module tb_tpram_wbuf_wrapper;

    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rd_req = 1'b0;
    logic            rd_ready;
    logic [AW-1:0]   rd_addr = '0;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic            wr_req = 1'b0;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic [DW/8-1:0] wr_be = '0;
    logic            wbuf_empty;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    tpram_wbuf_wrapper #(.DW(DW), .AW(AW), .DEPTH(32), .WB_DEPTH(4), .STARVE_LIM(8)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .wbuf_empty(wbuf_empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rd_valid) obs_q.push_back(rd_data);

    task automatic drive(input logic r, input logic [AW-1:0] ra, input logic w,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [3:0] be);
        @(negedge clk);
        rd_req  = r;
        rd_addr = ra;
        wr_req  = w;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0);
    endtask

    task automatic write_idle(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(1'b0, 5'd0, 1'b1, a, d, 4'hF);
        idle(2);
    endtask

    task automatic wait_reads(input int n);
        for (int i = 0; i < 20 && obs_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (rd_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 32'h0)   begin n_bad++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        n_cmp++; if (wbuf_empty !== 1'b1) begin n_bad++; $display("FAIL reset_wbuf_empty got %b want 1", wbuf_empty); end
        n_cmp++; if (wr_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        n_cmp++; if (rd_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_rd_ready got %b want 1", rd_ready); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [DW-1:0] e, o;
        drive(1'b0, 5'd0, 1'b1, 5'd3, 32'hDEADBEEF, 4'hF);
        idle(3);
        drive(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 4'h0);
        exp_q.push_back(32'hDEADBEEF);
        idle(1);
        #1;
        n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid_pulse got %b want 1", rd_valid); end
        idle(1);
        #1;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL basic_data_hold got %h want deadbeef", rd_data); end
        wait_reads(exp_q.size());
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL basic_read got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_forward;
        logic [DW-1:0] e, o;
        write_idle(5'd5, 32'h99999999);
        write_idle(5'd9, 32'h12345678);
        drive(1'b1, 5'd9, 1'b1, 5'd5, 32'h11223344, 4'hF); exp_q.push_back(32'h12345678);
        drive(1'b1, 5'd9, 1'b1, 5'd5, 32'hAABBCCDD, 4'h5); exp_q.push_back(32'h12345678);
        drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 4'h0);        exp_q.push_back(32'h11BB33DD);
        #1;
        n_cmp++; if (wbuf_empty !== 1'b0) begin n_bad++; $display("FAIL fwd_buffered got %b want 0", wbuf_empty); end
        idle(4);
        #1;
        n_cmp++; if (wbuf_empty !== 1'b1) begin n_bad++; $display("FAIL fwd_drained got %b want 1", wbuf_empty); end
        drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 4'h0);        exp_q.push_back(32'h11BB33DD);
        idle(1);
        wait_reads(exp_q.size());
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL fwd_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL fwd_read got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_collision;
        logic [DW-1:0] e, o;
        write_idle(5'd7, 32'h0);
        drive(1'b1, 5'd7, 1'b1, 5'd7, 32'h55, 4'hF); exp_q.push_back(32'h0);
        idle(2);
        drive(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 4'h0);  exp_q.push_back(32'h55);
        idle(1);
        wait_reads(exp_q.size());
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL coll_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL coll_read got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] e, o;
        logic exp_wr, exp_rd;
        int w = 0;
        for (int k = 0; k < 14; k++) begin
            drive(1'b1, 5'd9, (w < 5), 5'(10 + w), 32'(w), 4'hF);
            #1;
            exp_wr = (k < 4) || (k == 12);
            exp_rd = (k != 11);
            n_cmp++; if (wr_ready !== exp_wr) begin n_bad++; $display("FAIL bp_wr_ready cyc %0d got %b want %b", k, wr_ready, exp_wr); end
            n_cmp++; if (rd_ready !== exp_rd) begin n_bad++; $display("FAIL bp_rd_ready cyc %0d got %b want %b", k, rd_ready, exp_rd); end
            if (rd_ready) exp_q.push_back(32'h12345678);
            if (w < 5 && wr_ready) w++;
        end
        idle(6);
        #1;
        n_cmp++; if (wbuf_empty !== 1'b1) begin n_bad++; $display("FAIL bp_drained got %b want 1", wbuf_empty); end
        wait_reads(exp_q.size());
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL bp_read got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_drain_order;
        logic [DW-1:0] e, o;
        write_idle(5'd0, 32'hA0B0C0D0);
        for (int k = 1; k <= 4; k++) drive(1'b0, 5'd0, 1'b1, 5'd0, 32'(k), 4'h1);
        idle(1);
        #1;
        n_cmp++; if (wbuf_empty !== 1'b0) begin n_bad++; $display("FAIL drain_last_pending got %b want 0", wbuf_empty); end
        idle(1);
        #1;
        n_cmp++; if (wbuf_empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b want 1", wbuf_empty); end
        drive(1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0); exp_q.push_back(32'hA0B0C004);
        idle(1);
        wait_reads(exp_q.size());
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL drain_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL drain_read got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] e, o;
        write_idle(5'd20, 32'h20202020);
        write_idle(5'd21, 32'h21212121);
        write_idle(5'd22, 32'h22222222);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd9, 1'b1, 5'(20 + k), 32'hFFFF0000 | 32'(k), 4'hF);
            exp_q.push_back(32'h12345678);
        end
        drive(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 4'h0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        #1;
        n_cmp++; if (wbuf_empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_wbuf_empty got %b want 1", wbuf_empty); end
        n_cmp++; if (rd_valid !== 1'b0)   begin n_bad++; $display("FAIL rstmid_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (wr_ready !== 1'b1)   begin n_bad++; $display("FAIL rstmid_wr_ready got %b want 1", wr_ready); end
        idle(3);
        drive(1'b1, 5'd20, 1'b0, 5'd0, 32'h0, 4'h0); exp_q.push_back(32'h20202020);
        drive(1'b1, 5'd21, 1'b0, 5'd0, 32'h0, 4'h0); exp_q.push_back(32'h21212121);
        drive(1'b1, 5'd22, 1'b0, 5'd0, 32'h0, 4'h0); exp_q.push_back(32'h22222222);
        idle(1);
        wait_reads(exp_q.size());
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rstmid_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rstmid_read got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_forward;
        test_collision;
        test_backpressure;
        test_drain_order;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tpram_wbuf_wrapper.md
Name: tpram_wbuf_wrapper

Overview:
- Parametrised pseudo-two-port RAM built on one single-port array, for small NPU register-file and queue storage.
- Presents independent read and write request ports on one clock; a write buffer absorbs write/read collisions.
- The buffer drains into the array in cycles with no read.
- Adds byte enables, read-after-write forwarding, backpressure and an anti-starvation forced drain.

Parameters:
- DW, 32, data width in bits; multiple of 8.
- AW, 5, address width.
- DEPTH, 32, array words; DEPTH <= 2^AW.
- WB_DEPTH, 4, write-buffer entries; power of 2, 2..8.
- STARVE_LIM, 8, consecutive full-buffer cycles with reads pending before a drain is forced.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rd_req  in  1  read request
- rd_ready  out  1  read accepted when rd_req && rd_ready
- rd_addr  in  AW  read address
- rd_valid  out  1  read data valid; one-cycle pulse
- rd_data  out  DW  read data
- wr_req  in  1  write request
- wr_ready  out  1  write accepted when wr_req && wr_ready
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_be  in  DW/8  byte enables; bit i covers bits [8i+7:8i]
- wbuf_empty  out  1  buffer empty and no drain in flight (flush indicator)

Behaviour:
- Reset state:
  - rd_valid=0, rd_data=0.
  - Buffer empty: wbuf_empty=1, wr_ready=1, rd_ready=1.
  - Starve counter 0.
  - Array contents are not reset.
- Clocking and latency:
  - One clock; the array is a 1-cycle-latency single-port RAM, one access per cycle.
  - Read accepted in cycle N → rd_valid=1 and rd_data in cycle N+1.
  - rd_data holds its value until the next accepted read.
- Write path:
  - Every accepted write enqueues {addr, data, be} into a FIFO write buffer, WB_DEPTH entries.
  - wr_ready = !full; combinational from the count only, not from wr_req.
  - A write with wr_be=0 is accepted and enqueued; it causes no array change.
- Port arbitration each cycle:
  - Accepted read → the array performs the read.
  - Else, buffer non-empty → pop head and write it to the array with its byte mask.
  - Enqueue and drain in the same cycle are allowed; count is unchanged.
- Forwarding:
  - At read acceptance, snapshot every buffer entry whose addr equals rd_addr.
  - Merge bytewise oldest to youngest over the array output; the youngest byte wins.
  - A write accepted in the same cycle as the read is NOT forwarded; the read returns pre-write data.
  - An entry drained in the read cycle cannot occur, because reads block drain.
- Anti-starvation:
  - Starve counter increments each cycle that the buffer is full and rd_req=1.
  - It clears on any drain or when the buffer is not full.
  - When the counter == STARVE_LIM-1: rd_ready=0 for the next cycle, the head is drained, and the counter clears.
  - Otherwise rd_ready=1.
- Out-of-range addresses (addr >= DEPTH):
  - Writes are dropped at drain.
  - Reads return 0 merged with any forwarded bytes.
- wbuf_empty = (count==0).
- Reset mid-operation: buffered writes are discarded and never reach the array; a pending rd_valid is cleared.

Test Plan:
- Basic write/read: write A=3 D=0xDEADBEEF be=0xF; idle 2 cycles; read A=3 → rd_valid next cycle with 0xDEADBEEF.
- Forwarding: with reads issued every cycle, write A=5 0x11223344 be=0xF, then A=5 0xAABBCCDD be=0x5, then read A=5 → 0x11BB33DD while the entries are still buffered (wbuf_empty=0).
- Same-cycle collision: array A=7=0x0; read A=7 and write A=7 0x55 in the same cycle → rd_data=0x0; a later read → 0x55.
- Full/backpressure: hold rd_req=1 continuously and issue 5 writes → wr_ready=0 after the 4th is accepted. After STARVE_LIM=8 full cycles, rd_ready=0 for exactly 1 cycle, one entry drains, and wr_ready=1 the following cycle.
- Drain ordering: 4 writes to the same A=0 with be=0x1 and data 0x01..0x04, no reads → wbuf_empty=1 after 4 cycles; a read then returns byte0=0x04.
- Reset mid-operation: 3 writes buffered and rst asserted 1 cycle → wbuf_empty=1, rd_valid=0, wr_ready=1; a read of those addresses returns the pre-write array values.
